// File: rtl/mini_risc_seq_pkg.sv
// Shared definitions for the control-word sequence player: FSM states,
// run modes and bit offsets of the CPU control fields inside a control word.
package mini_risc_seq_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2,
    S_DONE  = 2'd3
  } seq_state_e;

  localparam logic [1:0] MODE_ONESHOT     = 2'b00;
  localparam logic [1:0] MODE_LOOP        = 2'b01;
  localparam logic [1:0] MODE_STEP        = 2'b10;
  localparam logic [1:0] MODE_ONESHOT_ALT = 2'b11;

  // One-bit control fields
  localparam int CW_REG_WRITE     = 0;
  localparam int CW_MEM_READ      = 1;
  localparam int CW_MEM_WRITE     = 2;
  localparam int CW_BRANCH        = 3;
  localparam int CW_JUMP          = 4;
  localparam int CW_IR_WRITE      = 5;
  localparam int CW_PC_WRITE      = 6;
  localparam int CW_PC_WRITE_COND = 7;
  localparam int CW_IORD          = 8;
  localparam int CW_SIGN_EXT      = 9;
  localparam int CW_HALT          = 10;
  localparam int CW_LINK_WRITE    = 11;
  localparam int CW_ZERO_EXT      = 12;
  // Two-bit control fields (offset of the LSB)
  localparam int CW_ALU_SRC_A     = 13;
  localparam int CW_ALU_SRC_B     = 15;
  localparam int CW_ALU_OP        = 17;
  localparam int CW_PC_SOURCE     = 19;
  localparam int CW_REG_DST       = 21;
  localparam int CW_MEM_TO_REG    = 23;

endpackage

// File: rtl/seq_table.sv
// Sequence table: DEPTH entries of {control word, repeat count}, one
// synchronous write port and one combinational read port. Never reset.
module seq_table #(
  parameter int CW_W  = 25,
  parameter int RPT_W = 4,
  parameter int DEPTH = 32,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [CW_W-1:0]   wword_i,
  input  logic [RPT_W-1:0]  wrpt_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [CW_W-1:0]   rword_o,
  output logic [RPT_W-1:0]  rrpt_o
);

  logic [CW_W+RPT_W-1:0] mem_q [DEPTH];

  // Table write port
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= {wword_i, wrpt_i};
    end
  end

  assign {rword_o, rrpt_o} = mem_q[raddr_i];

endmodule

// File: rtl/ctrl_seq_player.sv
// Plays a stored sequence of CPU control words, each held for rpt+1 cycles,
// in one-shot, loop or single-step mode.
module ctrl_seq_player
  import mini_risc_seq_pkg::*;
#(
  parameter int CW_W  = 25,
  parameter int DEPTH = 32,
  parameter int RPT_W = 4,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [CW_W-1:0]   load_word,
  input  logic [RPT_W-1:0]  load_rpt,
  input  logic [ADDR_W-1:0] last_idx,
  input  logic [1:0]        mode,
  input  logic              start,
  input  logic              step,
  input  logic              abort,
  output logic [CW_W-1:0]   ctrl_out,
  output logic              ctrl_valid,
  output logic [ADDR_W-1:0] idx_out,
  output logic              busy,
  output logic              done,
  output logic              load_err
);

  localparam logic [ADDR_W-1:0] LAST_MAX = ADDR_W'(DEPTH - 1);

  seq_state_e        state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d, last_q, last_d;
  logic [1:0]        mode_q, mode_d;
  logic [RPT_W-1:0]  rpt_q, rpt_d;
  logic [CW_W-1:0]   ctrl_q, ctrl_d;
  logic              valid_q, valid_d, done_q, load_err_q;
  logic              tbl_we_s;
  logic [ADDR_W-1:0] nxt_idx_s, rd_addr_s, last_clamp_s;
  logic [CW_W-1:0]   tbl_word_s, rd_word_s;
  logic [RPT_W-1:0]  tbl_rpt_s, rd_rpt_s;

  assign tbl_we_s     = load_en && (state_q == S_IDLE) && !rst;
  assign nxt_idx_s    = (idx_q == last_q) ? {ADDR_W{1'b0}} : idx_q + ADDR_W'(1);
  assign rd_addr_s    = (state_q == S_IDLE) ? {ADDR_W{1'b0}} : nxt_idx_s;
  assign last_clamp_s = (last_idx > LAST_MAX) ? LAST_MAX : last_idx;

  seq_table #(
    .CW_W  (CW_W),
    .RPT_W (RPT_W),
    .DEPTH (DEPTH)
  ) u_table (
    .clk     (clk),
    .we_i    (tbl_we_s),
    .waddr_i (load_addr),
    .wword_i (load_word),
    .wrpt_i  (load_rpt),
    .raddr_i (rd_addr_s),
    .rword_o (tbl_word_s),
    .rrpt_o  (tbl_rpt_s)
  );

  // A load landing on the same edge as the read must be seen by that read
  always_comb begin
    if (tbl_we_s && (load_addr == rd_addr_s)) begin
      rd_word_s = load_word;
      rd_rpt_s  = load_rpt;
    end else begin
      rd_word_s = tbl_word_s;
      rd_rpt_s  = tbl_rpt_s;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    last_d  = last_q;
    mode_d  = mode_q;
    rpt_d   = rpt_q;
    ctrl_d  = {CW_W{1'b0}};
    valid_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          idx_d   = {ADDR_W{1'b0}};
          last_d  = last_clamp_s;
          mode_d  = mode;
          rpt_d   = rd_rpt_s;
          ctrl_d  = rd_word_s;
          valid_d = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        if (rpt_q != {RPT_W{1'b0}}) begin
          rpt_d   = rpt_q - RPT_W'(1);
          ctrl_d  = ctrl_q;
          valid_d = 1'b1;
        end else if (mode_q == MODE_STEP) begin
          state_d = S_PAUSE;
        end else if ((idx_q != last_q) || (mode_q == MODE_LOOP)) begin
          idx_d   = nxt_idx_s;
          rpt_d   = rd_rpt_s;
          ctrl_d  = rd_word_s;
          valid_d = 1'b1;
        end else begin
          state_d = S_DONE;
        end
      end
      S_PAUSE: begin
        if (step && (idx_q == last_q)) begin
          state_d = S_DONE;
        end else if (step) begin
          state_d = S_RUN;
          idx_d   = nxt_idx_s;
          rpt_d   = rd_rpt_s;
          ctrl_d  = rd_word_s;
          valid_d = 1'b1;
        end else begin
          state_d = S_PAUSE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        idx_d   = {ADDR_W{1'b0}};
      end
      default: begin
        state_d = S_IDLE;
        idx_d   = {ADDR_W{1'b0}};
      end
    endcase
    if (abort) begin
      state_d = S_IDLE;
      idx_d   = {ADDR_W{1'b0}};
      rpt_d   = {RPT_W{1'b0}};
      ctrl_d  = {CW_W{1'b0}};
      valid_d = 1'b0;
    end else begin
      state_d = state_d;
    end
  end

  // State and output registers; the table itself is left untouched by rst
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      idx_q      <= {ADDR_W{1'b0}};
      last_q     <= {ADDR_W{1'b0}};
      mode_q     <= 2'b00;
      rpt_q      <= {RPT_W{1'b0}};
      ctrl_q     <= {CW_W{1'b0}};
      valid_q    <= 1'b0;
      done_q     <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      last_q     <= last_d;
      mode_q     <= mode_d;
      rpt_q      <= rpt_d;
      ctrl_q     <= ctrl_d;
      valid_q    <= valid_d;
      done_q     <= (state_d == S_DONE);
      load_err_q <= load_en && (state_q != S_IDLE);
    end
  end

  assign ctrl_out   = ctrl_q;
  assign ctrl_valid = valid_q;
  assign idx_out    = idx_q;
  assign busy       = (state_q != S_IDLE);
  assign done       = done_q;
  assign load_err   = load_err_q;

endmodule

// File: tb/tb_ctrl_seq_player.sv
// Scoreboard bench for ctrl_seq_player: each driven cycle pushes the output
// expected after the next rising edge; a negedge monitor pops and compares.
module tb_ctrl_seq_player;
  import mini_risc_seq_pkg::*;

  localparam int CW_W  = 25;
  localparam int DEPTH = 32;
  localparam int RPT_W = 4;
  localparam int AW    = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst, load_en, start, step, abort;
  logic [AW-1:0]    load_addr, last_idx, idx_out;
  logic [CW_W-1:0]  load_word, ctrl_out;
  logic [RPT_W-1:0] load_rpt;
  logic [1:0]       mode;
  logic             ctrl_valid, busy, done, load_err;

  ctrl_seq_player #(.CW_W(CW_W), .DEPTH(DEPTH), .RPT_W(RPT_W)) dut (
    .clk(clk), .rst(rst), .load_en(load_en), .load_addr(load_addr),
    .load_word(load_word), .load_rpt(load_rpt), .last_idx(last_idx),
    .mode(mode), .start(start), .step(step), .abort(abort),
    .ctrl_out(ctrl_out), .ctrl_valid(ctrl_valid), .idx_out(idx_out),
    .busy(busy), .done(done), .load_err(load_err)
  );

  typedef struct packed {
    logic [CW_W-1:0] word;
    logic            valid;
    logic [AW-1:0]   idx;
    logic            chk_idx;
    logic            busy;
    logic            done;
    logic            lerr;
  } exp_t;

  exp_t             sb_q[$];
  exp_t             m_e;
  logic [CW_W-1:0]  tb_word [DEPTH];
  logic [RPT_W-1:0] tb_rpt  [DEPTH];
  int               n_chk = 0;
  int               n_err = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp_v);
    n_chk++;
    if (act !== exp_v) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, act, exp_v);
    end
  endtask

  function automatic exp_t e_idle();
    exp_t e = '0;
    e.chk_idx = 1'b1;
    return e;
  endfunction

  function automatic exp_t e_ent(input int i);
    exp_t e = '0;
    e.word = tb_word[i]; e.valid = 1'b1; e.idx = i[AW-1:0];
    e.chk_idx = 1'b1; e.busy = 1'b1;
    return e;
  endfunction

  function automatic exp_t e_pause();
    exp_t e = '0;
    e.busy = 1'b1;
    return e;
  endfunction

  function automatic exp_t e_done(input int last);
    exp_t e = '0;
    e.idx = last[AW-1:0]; e.chk_idx = 1'b1; e.busy = 1'b1; e.done = 1'b1;
    return e;
  endfunction

  function automatic logic [CW_W-1:0] rand_word();
    logic [CW_W-1:0] w;
    w = CW_W'($urandom);
    w[CW_REG_WRITE] = 1'b1;
    return w;
  endfunction

  // Advance to the next drive point, drop pulse inputs, record expectation
  task automatic nxt(input exp_t e);
    @(negedge clk); #1;
    start = 1'b0; step = 1'b0; abort = 1'b0; load_en = 1'b0; rst = 1'b0;
    sb_q.push_back(e);
  endtask

  task automatic load(input int a, input logic [CW_W-1:0] w, input logic [RPT_W-1:0] r);
    nxt(e_idle());
    load_en = 1'b1; load_addr = a[AW-1:0]; load_word = w; load_rpt = r;
    tb_word[a] = w; tb_rpt[a] = r;
  endtask

  task automatic start_run(input int last, input logic [1:0] m);
    nxt(e_ent(0));
    start = 1'b1; last_idx = last[AW-1:0]; mode = m;
  endtask

  task automatic hold(input int i, input int n);
    for (int k = 0; k < n; k++) nxt(e_ent(i));
  endtask

  // Full one-shot run; stray start/step and changed last_idx/mode must be ignored
  task automatic oneshot(input int last, input logic [1:0] m);
    start_run(last, m);
    for (int k = 0; k < int'(tb_rpt[0]); k++) begin
      nxt(e_ent(0));
      last_idx = '0; mode = MODE_LOOP;
      start = (k == 0); step = (k == 0);
    end
    for (int i = 1; i <= last; i++) hold(i, int'(tb_rpt[i]) + 1);
    nxt(e_done(last));
    nxt(e_idle());
  endtask

  always @(negedge clk) begin
    if (sb_q.size() != 0) begin
      m_e = sb_q.pop_front();
      check("ctrl_out", 64'(ctrl_out), 64'(m_e.word));
      check("ctrl_valid", 64'(ctrl_valid), 64'(m_e.valid));
      check("busy", 64'(busy), 64'(m_e.busy));
      check("done", 64'(done), 64'(m_e.done));
      check("load_err", 64'(load_err), 64'(m_e.lerr));
      if (m_e.chk_idx) check("idx_out", 64'(idx_out), 64'(m_e.idx));
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    exp_t e;
    logic [CW_W-1:0] w;
    rst = 1'b1; load_en = 1'b0; start = 1'b0; step = 1'b0; abort = 1'b0;
    load_addr = '0; load_word = '0; load_rpt = '0; last_idx = '0; mode = 2'b00;
    repeat (2) @(posedge clk);
    nxt(e_idle()); rst = 1'b1;
    nxt(e_idle());

    // Basic one-shot: hold times 4,1,1 then done
    load(0, rand_word(), 4'd3);
    load(1, rand_word(), 4'd0);
    load(2, rand_word(), 4'd0);
    oneshot(2, MODE_ONESHOT);

    // Loop A,B,A,B... then abort
    load(0, rand_word(), 4'd0);
    load(1, rand_word(), 4'd0);
    start_run(1, MODE_LOOP);
    for (int it = 0; it < 3; it++) begin
      nxt(e_ent(1));
      nxt(e_ent(0));
    end
    nxt(e_idle()); abort = 1'b1;
    nxt(e_idle());

    // Abort on the final cycle of a one-shot beats the done pulse
    start_run(1, MODE_ONESHOT);
    nxt(e_ent(1));
    nxt(e_idle()); abort = 1'b1;
    nxt(e_idle());

    // Single-step with pauses
    load(0, rand_word(), 4'd1);
    load(1, rand_word(), 4'd1);
    start_run(1, MODE_STEP);
    nxt(e_ent(0));
    nxt(e_pause());
    nxt(e_pause());
    nxt(e_pause()); start = 1'b1;
    nxt(e_ent(1)); step = 1'b1;
    nxt(e_ent(1));
    nxt(e_pause());
    nxt(e_done(1)); step = 1'b1;
    nxt(e_idle());

    // Load together with start on entry 0, then rejected load mid-run
    load(1, rand_word(), 4'd1);
    load(2, rand_word(), 4'd1);
    w = rand_word();
    tb_word[0] = w; tb_rpt[0] = 4'd2;
    nxt(e_ent(0));
    start = 1'b1; last_idx = 5'd2; mode = MODE_ONESHOT;
    load_en = 1'b1; load_addr = 5'd0; load_word = w; load_rpt = 4'd2;
    hold(0, 2);
    e = e_ent(1); e.lerr = 1'b1;
    nxt(e);
    load_en = 1'b1; load_addr = 5'd1; load_word = ~tb_word[1]; load_rpt = 4'd0;
    nxt(e_ent(1));
    hold(2, 2);
    nxt(e_done(2));
    nxt(e_idle());
    oneshot(2, MODE_ONESHOT);

    // Reset at entry 5 of a running sequence, then clean replay
    for (int a = 0; a < 8; a++) load(a, rand_word(), 4'd0);
    start_run(7, MODE_ONESHOT);
    for (int i = 1; i <= 5; i++) nxt(e_ent(i));
    nxt(e_idle()); rst = 1'b1;
    nxt(e_idle());
    oneshot(7, MODE_ONESHOT);

    // Full table, maximum repeat, mode 11 behaves as one-shot
    for (int a = 0; a < DEPTH; a++) load(a, rand_word(), 4'd15);
    oneshot(DEPTH - 1, MODE_ONESHOT_ALT);

    repeat (3) nxt(e_idle());
    for (int k = 0; k < 4 && sb_q.size() != 0; k++) @(negedge clk);
    #1;
    check("sb_drain", 64'(sb_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
